// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush/freeze arbiter with D-cache wait watchdog.
// Define PERF_CNT_EN to add load-use, branch and freeze event counters.
module hazard_stall_ctrl #(
    parameter int BRANCH_PENALTY = 1,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  id_rs_addr_i,
    input  logic [4:0]  id_rt_addr_i,
    input  logic        id_uses_rt_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  ex_rt_addr_i,
    input  logic        branch_taken_i,
    input  logic        icache_stall_i,
    input  logic        dcache_stall_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_bubble_o,
    output logic        pipe_freeze_o,
    output logic        mem_timeout_o,
    output logic [1:0]  state_o
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] perf_lu_stalls_o,
    output logic [31:0] perf_br_flushes_o,
    output logic [31:0] perf_mem_cycles_o
`endif
);
    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2} state_e;
    localparam logic [2:0]  RELOAD = 3'(BRANCH_PENALTY - 1);
    localparam logic [15:0] WMAX   = 16'(MEM_TIMEOUT);
    state_e      state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        timeout_q, timeout_d;
    logic        lu, in_flush;
    assign lu = ex_memread_i && ex_rt_addr_i != 5'd0 &&
                (ex_rt_addr_i == id_rs_addr_i || (id_uses_rt_i && ex_rt_addr_i == id_rt_addr_i));
    assign in_flush      = state_q == FLUSH;
    assign state_o       = state_q;
    assign mem_timeout_o = timeout_q;
    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
        pipe_freeze_o = 1'b0;
        if (!rst_ni) begin
            pc_write_o = 1'b0;
        end else if (dcache_stall_i) begin
            // ID/EX must hold, otherwise the instruction in EX is lost
            pipe_freeze_o = 1'b1;
            ifid_flush_o  = 1'b0;
            idex_bubble_o = 1'b0;
        end else if (branch_taken_i) begin
            pc_write_o = 1'b1;
        end else if (in_flush) begin
            pc_write_o = !icache_stall_i;
        end else if (lu) begin
            ifid_flush_o = 1'b0;
        end else if (icache_stall_i) begin
            idex_bubble_o = 1'b0;
        end else begin
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            ifid_flush_o  = 1'b0;
            idex_bubble_o = 1'b0;
        end
    end
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        wcnt_d    = '0;
        timeout_d = timeout_q;
        if (dcache_stall_i) begin
            state_d   = MEM_WAIT;
            wcnt_d    = (wcnt_q == WMAX) ? wcnt_q : wcnt_q + 16'd1;
            timeout_d = timeout_q || wcnt_d == WMAX;
        end else if (branch_taken_i) begin
            state_d = (BRANCH_PENALTY > 1) ? FLUSH : RUN;
            fcnt_d  = RELOAD;
        end else if (in_flush) begin
            fcnt_d  = (fcnt_q == 3'd0) ? 3'd0 : fcnt_q - 3'd1;
            state_d = (fcnt_q <= 3'd1) ? RUN : FLUSH;
        end else begin
            state_d = (fcnt_q != 3'd0) ? FLUSH : RUN;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RUN;
            fcnt_q    <= '0;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end
`ifdef PERF_CNT_EN
    logic lu_ev, br_ev;
    assign lu_ev = !dcache_stall_i && !branch_taken_i && !in_flush && lu;
    assign br_ev = !dcache_stall_i && branch_taken_i;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_lu_stalls_o  <= '0;
            perf_br_flushes_o <= '0;
            perf_mem_cycles_o <= '0;
        end else begin
            perf_lu_stalls_o  <= perf_lu_stalls_o + 32'(lu_ev);
            perf_br_flushes_o <= perf_br_flushes_o + 32'(br_ev);
            perf_mem_cycles_o <= perf_mem_cycles_o + 32'(dcache_stall_i);
        end
    end
`endif
endmodule
